// File: rtl/spram_rr_arbiter.sv
// Two-port round-robin front end for a single-port RAM.
// Read tags ride a ReadLatency-deep pipeline to steer returning data.
module spram_rr_arbiter #(
    parameter int ReadLatency  = 1,
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic                    p0_req_we,
    input  logic [AddrBusWidth-1:0] p0_req_addr,
    input  logic [DataBusWidth-1:0] p0_req_wdata,
    output logic                    p0_rsp_valid,
    output logic [DataBusWidth-1:0] p0_rsp_data,
    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic                    p1_req_we,
    input  logic [AddrBusWidth-1:0] p1_req_addr,
    input  logic [DataBusWidth-1:0] p1_req_wdata,
    output logic                    p1_rsp_valid,
    output logic [DataBusWidth-1:0] p1_rsp_data,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [AddrBusWidth-1:0] mem_addr,
    output logic [DataBusWidth-1:0] mem_w_data,
    input  logic [DataBusWidth-1:0] mem_r_data
);

    logic prio_q, prio_d;
    logic gnt0, gnt1, xfer, sel_we;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0_req_valid && (!p1_req_valid || !prio_q)) gnt0 = 1'b1;
            else if (p1_req_valid)                          gnt1 = 1'b1;
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign xfer         = gnt0 | gnt1;
    assign sel_we       = gnt1 ? p1_req_we : p0_req_we;
    assign mem_re       = xfer & ~sel_we;
    assign mem_we       = xfer & sel_we;

    always_comb begin
        mem_addr   = '0;
        mem_w_data = '0;
        if (gnt1) begin
            mem_addr   = p1_req_addr;
            mem_w_data = p1_req_wdata;
        end else if (gnt0) begin
            mem_addr   = p0_req_addr;
            mem_w_data = p0_req_wdata;
        end
    end

    // The port that just transferred drops to lowest priority.
    always_comb begin
        prio_d = prio_q;
        if (gnt0)      prio_d = 1'b1;
        else if (gnt1) prio_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end

    assign p0_rsp_data = mem_r_data;
    assign p1_rsp_data = mem_r_data;

    generate
        if (ReadLatency == 0) begin : g_comb
            assign p0_rsp_valid = mem_re & gnt0;
            assign p1_rsp_valid = mem_re & gnt1;
        end else begin : g_pipe
            logic [ReadLatency-1:0] vld_q, vld_d;
            logic [ReadLatency-1:0] port_q, port_d;

            always_comb begin
                vld_d     = vld_q;
                port_d    = port_q;
                vld_d[0]  = mem_re;
                port_d[0] = gnt1;
                for (int i = 1; i < ReadLatency; i++) begin
                    vld_d[i]  = vld_q[i-1];
                    port_d[i] = port_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= '0;
                    port_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    port_q <= port_d;
                end
            end

            // Gate with rst so tags still in flight at reset assertion stay silent.
            assign p0_rsp_valid = ~rst & vld_q[ReadLatency-1]
                                & ~port_q[ReadLatency-1];
            assign p1_rsp_valid = ~rst & vld_q[ReadLatency-1]
                                & port_q[ReadLatency-1];
        end
    endgenerate

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Bench for spram_rr_arbiter: latencies 1, 3 and 0 side by side,
// shared stimulus, per-instance RAM model and response scoreboard.
module tb_spram_rr_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, preload;
    logic          v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;

    logic          rdy0 [3];
    logic          rdy1 [3];
    logic          rv0  [3];
    logic          rv1  [3];
    logic          mre  [3];
    logic          mwe  [3];
    logic [AW-1:0] maddr[3];
    logic [DW-1:0] mwd  [3];
    logic [DW-1:0] rd0  [3];
    logic [DW-1:0] rd1  [3];
    logic [DW-1:0] mrd  [3];

    function automatic logic [DW-1:0] pat(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'hA500_0000 | a;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : (k == 1) ? 3 : 0;
        logic [DW-1:0] ram [64];
        logic [DW-1:0] pipe[4];

        spram_rr_arbiter #(
            .ReadLatency (L),
            .AddrBusWidth(AW),
            .DataBusWidth(DW)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .p0_req_valid(v0),
            .p0_req_ready(rdy0[k]),
            .p0_req_we   (we0),
            .p0_req_addr (a0),
            .p0_req_wdata(wd0),
            .p0_rsp_valid(rv0[k]),
            .p0_rsp_data (rd0[k]),
            .p1_req_valid(v1),
            .p1_req_ready(rdy1[k]),
            .p1_req_we   (we1),
            .p1_req_addr (a1),
            .p1_req_wdata(wd1),
            .p1_rsp_valid(rv1[k]),
            .p1_rsp_data (rd1[k]),
            .mem_re      (mre[k]),
            .mem_we      (mwe[k]),
            .mem_addr    (maddr[k]),
            .mem_w_data  (mwd[k]),
            .mem_r_data  (mrd[k])
        );

        always @(posedge clk) begin
            if (preload) begin
                for (int a = 0; a < 64; a++) ram[a] <= pat(a);
            end else if (mwe[k]) begin
                ram[maddr[k][5:0]] <= mwd[k];
            end
            pipe[0] <= ram[maddr[k][5:0]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        if (L == 0) begin : g_l0
            assign mrd[k] = ram[maddr[k][5:0]];
        end else begin : g_ln
            assign mrd[k] = pipe[L-1];
        end
    end

    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[3][$];
    logic [DW-1:0] mm[64];
    bit            prio_m, g0, g1, s_r0, s_r1;
    int            cyc, n_cmp, n_bad;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit            we, rd, e0, e1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        exp_t          e;
        @(negedge clk);
        g0 = !rst && v0 && (!v1 || !prio_m);
        g1 = !rst && v1 && !g0;
        we = g1 ? we1 : we0;
        rd = (g0 || g1) && !we;
        ea = g1 ? a1 : (g0 ? a0 : '0);
        ew = g1 ? wd1 : (g0 ? wd0 : '0);
        s_r0 = rdy0[0];
        s_r1 = rdy1[0];
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rdy0[%0d]@%0d", k, cyc), rdy0[k], g0);
            chk($sformatf("rdy1[%0d]@%0d", k, cyc), rdy1[k], g1);
            chk($sformatf("re[%0d]@%0d", k, cyc), mre[k], rd);
            chk($sformatf("we[%0d]@%0d", k, cyc), mwe[k],
                (g0 || g1) && we);
            chk($sformatf("addr[%0d]@%0d", k, cyc), maddr[k], ea);
            chk($sformatf("wdat[%0d]@%0d", k, cyc), mwd[k], ew);
            if (rd) sb[k].push_back('{cyc + lat(k), g1, mm[ea[5:0]]});
            e0 = 1'b0;
            e1 = 1'b0;
            if (rst) begin
                sb[k].delete();
            end else if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                e = sb[k].pop_front();
                e0 = !e.port;
                e1 = e.port;
                if (e.port)
                    chk($sformatf("rd1[%0d]@%0d", k, cyc), rd1[k], e.data);
                else
                    chk($sformatf("rd0[%0d]@%0d", k, cyc), rd0[k], e.data);
            end
            chk($sformatf("rv0[%0d]@%0d", k, cyc), rv0[k], e0);
            chk($sformatf("rv1[%0d]@%0d", k, cyc), rv1[k], e1);
        end
        if (rst)     prio_m = 1'b0;
        else if (g0) prio_m = 1'b1;
        else if (g1) prio_m = 1'b0;
        if ((g0 || g1) && we) mm[ea[5:0]] = ew;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int n0, n1;

    initial begin
        for (int a = 0; a < 64; a++) mm[a] = pat(a);
        rst = 1'b1; preload = 1'b1;
        v0 = 1'b1; we0 = 1'b0; a0 = '0; wd0 = '0;
        v1 = 1'b1; we1 = 1'b0; a1 = 32'h1; wd1 = '0;
        repeat (3) step();

        preload = 1'b0; rst = 1'b0;
        v1 = 1'b0; a0 = 32'h10;
        step();
        chk("single_rdy", s_r0, 1'b1);
        v0 = 1'b0;
        repeat (4) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        v0 = 1'b1; v1 = 1'b1; a0 = '0; a1 = 32'h30; n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("cont_p1_%0d", i), s_r1, i % 2);
            if (g0) begin n0++; a0 = n0; end
            if (g1) begin n1++; a1 = 32'h30 + n1; end
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) step();

        v1 = 1'b1; we1 = 1'b1; a1 = 32'h20; wd1 = 32'h1234;
        step();
        v1 = 1'b0; we1 = 1'b0; v0 = 1'b1; a0 = 32'h20;
        step();
        v0 = 1'b0;
        repeat (4) step();

        v0 = 1'b1; a0 = 32'h4;
        step();
        v0 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();

        v1 = 1'b1; a1 = 32'h4;
        step();
        v1 = 1'b0;
        repeat (4) step();

        for (int k = 0; k < 3; k++)
            chk($sformatf("sb_left[%0d]", k), sb[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
